// File: rtl/seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// seg7_scan_reader
//
// Reader side of a multiplexed, active-low 7-segment display bus. The
// anode-select and segment lines driven by a display scanner are registered
// every cycle. A pattern is captured only after it has stayed identical for
// STABLE_CYCLES consecutive samples. When captured, it is decoded back to
// BCD and written into a per-digit shadow of what the panel currently shows.
//
// Ports:
//   iClk        system clock (all state updates on its rising edge)
//   iRst_n      synchronous active-low reset
//   iAn         anode selects, active-low, bit i low selects digit i
//   iSeg        segment bus, active-low, bit order {g,f,e,d,c,b,a}
//   iClrErr     clears the sticky error flag
//   oDigits     decoded value of digit i on bits [4i+3:4i]
//               (4'hF = blank, 4'hE = illegal pattern)
//   oValidMask  bit i high when slot i holds a numeral 0-9
//   oUpdate     one-cycle pulse following every capture
//   oErr        sticky flag, set when an illegal segment pattern is captured
// ---------------------------------------------------------------------------
module seg7_scan_reader #(
   parameter int DIGITS        = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  iClk,
   input  logic                  iRst_n,
   input  logic [DIGITS-1:0]     iAn,
   input  logic [6:0]            iSeg,
   input  logic                  iClrErr,
   output logic [4*DIGITS-1:0]   oDigits,
   output logic [DIGITS-1:0]     oValidMask,
   output logic                  oUpdate,
   output logic                  oErr
);

   localparam int              SAMPLE_W   = DIGITS + 7;
   localparam logic [3:0]      STABLE_LIM = 4'(STABLE_CYCLES);
   localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic [SAMPLE_W-1:0] prev_q, prev_d;
   logic [3:0]          run_q, run_d;
   logic                captured_q, captured_d;
   logic [4*DIGITS-1:0] digits_q, digits_d;
   logic [DIGITS-1:0]   valid_q, valid_d;
   logic                update_q, update_d;
   logic                err_q, err_d;

   logic [DIGITS-1:0]   an_sel;
   logic [6:0]          seg;
   logic                anode_legal;
   logic                same_sample;
   logic                capture;
   logic [3:0]          dec_val;
   logic                dec_valid;
   logic                dec_illegal;

   // Input sampling stage: the raw buses are registered every cycle, so
   // every later decision works on a clean, synchronous copy. The previous
   // sample is kept so the run counter can detect an unchanged pattern.
   always_comb begin
      sample_d = {iAn, iSeg};
      prev_d   = sample_q;
   end

   // Anode legality and the segment decode table. The anode bus is
   // inverted so the selected digit becomes a one-hot vector; a sample is
   // legal only when exactly one bit is set. The x & (x-1) trick clears the
   // lowest set bit, so a zero result means at most one bit was set.
   always_comb begin
      an_sel      = ~sample_q[SAMPLE_W-1:7];
      seg         = sample_q[6:0];
      anode_legal = (an_sel != '0) && ((an_sel & (an_sel - AN_ONE)) == '0);
      same_sample = (sample_q == prev_q);

      dec_val     = 4'hE;
      dec_valid   = 1'b0;
      dec_illegal = 1'b0;
      case (seg)
         7'b1000000: begin dec_val = 4'd0; dec_valid = 1'b1; end
         7'b1111001: begin dec_val = 4'd1; dec_valid = 1'b1; end
         7'b0100100: begin dec_val = 4'd2; dec_valid = 1'b1; end
         7'b0110000: begin dec_val = 4'd3; dec_valid = 1'b1; end
         7'b0011001: begin dec_val = 4'd4; dec_valid = 1'b1; end
         7'b0010010: begin dec_val = 4'd5; dec_valid = 1'b1; end
         7'b0000010: begin dec_val = 4'd6; dec_valid = 1'b1; end
         7'b1111000: begin dec_val = 4'd7; dec_valid = 1'b1; end
         7'b0000000: begin dec_val = 4'd8; dec_valid = 1'b1; end
         7'b0010000: begin dec_val = 4'd9; dec_valid = 1'b1; end
         7'b1111111: begin dec_val = 4'hF; end
         default:    begin dec_val = 4'hE; dec_illegal = 1'b1; end
      endcase
   end

   // Dwell tracking. A non-legal sample (blanking or several anodes low)
   // restarts everything. A changed legal pattern starts a new dwell with
   // a count of one. An unchanged legal pattern counts up and saturates.
   // The captured flag makes each dwell capture exactly once, even when
   // the scanner lingers far longer than STABLE_CYCLES.
   always_comb begin
      run_d      = run_q;
      captured_d = captured_q;
      capture    = 1'b0;

      if (!anode_legal) begin
         run_d      = 4'd0;
         captured_d = 1'b0;
      end else if (!same_sample) begin
         run_d      = 4'd1;
         captured_d = 1'b0;
      end else if (run_q != STABLE_LIM) begin
         run_d = run_q + 4'd1;
      end

      if (anode_legal && same_sample && (run_d == STABLE_LIM) && !captured_q) begin
         capture    = 1'b1;
         captured_d = 1'b1;
      end
   end

   // Shadow update. Only the slot whose anode is selected is written; all
   // other slots keep their value. The error flag is sticky, and a new
   // illegal capture takes priority over a clear on the same edge so that
   // no error event can be lost.
   always_comb begin
      digits_d = digits_q;
      valid_d  = valid_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (capture && an_sel[i]) begin
            digits_d[4*i +: 4] = dec_val;
            valid_d[i]         = dec_valid;
         end
      end

      update_d = capture;

      if (capture && dec_illegal) begin
         err_d = 1'b1;
      end else if (iClrErr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // State registers with synchronous active-low reset. The sample
   // registers reset to all ones, which reads as a blanked, non-legal bus.
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         sample_q   <= '1;
         prev_q     <= '1;
         run_q      <= 4'd0;
         captured_q <= 1'b0;
         digits_q   <= '1;
         valid_q    <= '0;
         update_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         sample_q   <= sample_d;
         prev_q     <= prev_d;
         run_q      <= run_d;
         captured_q <= captured_d;
         digits_q   <= digits_d;
         valid_q    <= valid_d;
         update_q   <= update_d;
         err_q      <= err_d;
      end
   end

   assign oDigits    = digits_q;
   assign oValidMask = valid_q;
   assign oUpdate    = update_q;
   assign oErr       = err_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_reader
//
// Self-checking bench for seg7_scan_reader (DIGITS=8, STABLE_CYCLES=4).
// The stimulus process drives directed dwells. For every dwell that should
// capture, it pushes the full expected output state into a queue. A
// monitor running on the falling edge pops one entry per oUpdate pulse and
// compares it. Any pulse that arrives with no entry queued is flagged.
// ---------------------------------------------------------------------------
module tb_seg7_scan_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        clr_err;
   logic [31:0] digits;
   logic [7:0]  valid_mask;
   logic        update;
   logic        err;

   typedef struct packed {
      logic [31:0] digits;
      logic [7:0]  mask;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks   = 0;
   int          failures = 0;
   int          update_count = 0;

   logic [31:0] m_digits;
   logic [7:0]  m_mask;
   logic        m_err;

   seg7_scan_reader #(.DIGITS(8), .STABLE_CYCLES(4)) dut (
      .iClk       (clk),
      .iRst_n     (rst_n),
      .iAn        (an),
      .iSeg       (seg),
      .iClrErr    (clr_err),
      .oDigits    (digits),
      .oValidMask (valid_mask),
      .oUpdate    (update),
      .oErr       (err)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it and reports any difference.
   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   // Active-low segment code for a BCD value.
   function automatic logic [6:0] seg_code(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Monitor: every update pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (update) begin
         update_count++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_update actual=pulse digits=%h required=no_pulse",
                     digits);
         end else begin
            mon_e = exp_q.pop_front();
            check_output("upd_digits", digits, mon_e.digits);
            check_output("upd_mask", {24'b0, valid_mask}, {24'b0, mon_e.mask});
            check_output("upd_err", {31'b0, err}, {31'b0, mon_e.err});
         end
      end
   end

   // Drives one dwell. A negative slot blanks all anodes. When a capture is
   // expected, the bench's shadow is updated with the hand-given value and
   // the resulting full state is queued for the monitor.
   task automatic apply_stimulus(input int slot, input logic [6:0] s, input int cycles,
                                 input bit expect_cap, input logic [3:0] val,
                                 input bit vld, input bit bad);
      logic [7:0] one8;
      one8 = 8'b1;
      if (expect_cap) begin
         m_digits[4*slot +: 4] = val;
         m_mask[slot]          = vld;
         if (bad) m_err = 1'b1;
         exp_q.push_back({m_digits, m_mask, m_err});
      end
      an  = (slot < 0) ? 8'hFF : ~(one8 << slot);
      seg = s;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // Bounded wait until every queued expectation has been consumed.
   task automatic drain(input string name);
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d_pending required=0_pending", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_output({tag, "_digits"}, digits, 32'hFFFF_FFFF);
      check_output({tag, "_mask"}, {24'b0, valid_mask}, 32'h0);
      check_output({tag, "_update"}, {31'b0, update}, 32'h0);
      check_output({tag, "_err"}, {31'b0, err}, 32'h0);
   endtask

   initial begin
      logic [31:0] frame;
      int          cnt_before;

      rst_n    = 1'b0;
      an       = 8'hFF;
      seg      = 7'h7F;
      clr_err  = 1'b0;
      m_digits = 32'hFFFF_FFFF;
      m_mask   = 8'h00;
      m_err    = 1'b0;

      // Reset, then idle with blanked anodes.
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst_n = 1'b1;
      apply_stimulus(-1, 7'h7F, 10, 0, 4'h0, 0, 0);
      check_output("idle_digits", digits, 32'hFFFF_FFFF);
      check_output("idle_mask", {24'b0, valid_mask}, 32'h0);
      check_output("idle_err", {31'b0, err}, 32'h0);

      // Digit 0 shows 5 for 10 cycles: exactly one capture.
      apply_stimulus(0, 7'b0010010, 10, 1, 4'd5, 1, 0);
      drain("drain_digit0");
      check_output("hold_no_repulse", {31'b0, update}, 32'h0);

      // 3-cycle glitch on digit 0, then digit 1 shows 1.
      apply_stimulus(-1, 7'h7F, 2, 0, 4'h0, 0, 0);
      apply_stimulus(0, 7'b0010010, 3, 0, 4'h0, 0, 0);
      apply_stimulus(1, 7'b1111001, 6, 1, 4'd1, 1, 0);
      drain("drain_digit1");
      check_output("glitch_digits", digits, 32'hFFFF_FF15);
      check_output("glitch_mask", {24'b0, valid_mask}, 32'h0000_0003);

      // Two full frames of "20221010" scanned from digit 7 down to 0.
      frame      = 32'h2022_1010;
      cnt_before = update_count;
      for (int f = 0; f < 2; f++) begin
         for (int d = 7; d >= 0; d--) begin
            apply_stimulus(d, seg_code(frame[4*d +: 4]), 6, 1, frame[4*d +: 4], 1, 0);
         end
      end
      drain("drain_frames");
      check_output("frame_digits", digits, 32'h2022_1010);
      check_output("frame_mask", {24'b0, valid_mask}, 32'h0000_00FF);
      check_output("frame_pulses", update_count - cnt_before, 32'd16);

      // Illegal pattern on digit 3 sets the error flag.
      apply_stimulus(3, 7'b0101010, 5, 1, 4'hE, 0, 1);
      drain("drain_illegal");
      check_output("illegal_err", {31'b0, err}, 32'h1);

      // Clear and a second illegal capture on the same edge: set wins.
      exp_q.push_back({m_digits, m_mask, 1'b1});
      an  = 8'b1111_0111;
      seg = 7'b0110110;
      repeat (4) @(posedge clk);
      #1;
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      drain("drain_clr_same_edge");
      check_output("clr_same_edge_err", {31'b0, err}, 32'h1);

      // Clear alone drops the flag.
      apply_stimulus(-1, 7'h7F, 1, 0, 4'h0, 0, 0);
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      m_err   = 1'b0;
      check_output("clr_alone_err", {31'b0, err}, 32'h0);

      // Two anodes low with a legal segment: never captures.
      an  = 8'b1111_1100;
      seg = 7'b1111001;
      repeat (10) @(posedge clk);
      #1;
      check_output("multi_an_digits", digits, 32'h2022_E010);
      check_output("multi_an_mask", {24'b0, valid_mask}, 32'h0000_00F7);
      check_output("multi_an_err", {31'b0, err}, 32'h0);

      // Reset in the middle of a legal dwell, then a full run afterwards.
      apply_stimulus(2, 7'b0000000, 2, 0, 4'h0, 0, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset_state("midrun_reset");
      rst_n    = 1'b1;
      m_digits = 32'hFFFF_FFFF;
      m_mask   = 8'h00;
      m_err    = 1'b0;
      m_digits[11:8] = 4'd8;
      m_mask[2]      = 1'b1;
      exp_q.push_back({m_digits, m_mask, m_err});
      repeat (3) @(posedge clk);
      #1;
      check_output("post_reset_early_digits", digits, 32'hFFFF_FFFF);
      drain("drain_post_reset");
      check_output("post_reset_digits", digits, 32'hFFFF_F8FF);

      apply_stimulus(-1, 7'h7F, 3, 0, 4'h0, 0, 0);
      drain("drain_final");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
